// File: rtl/line_memory_ctrl_if.sv
// ---------------------------------------------------------------------------
// line_memory_ctrl_if
//
// Purpose:
//   Request/response bundle between the dcache controller (master) and the
//   line memory controller (slave). A request is one whole cache line, either
//   a refill read or a dirty-line write-back.
//
// Signals:
//   addr_i    master->slave  32      byte address, bits [4:0] ignored
//   enable_i  master->slave  1       request valid
//   write_i   master->slave  1       1 = write line, 0 = read line
//   data_i    master->slave  LINE_W  write line data
//   ack_o     slave->master  1       one-cycle completion pulse
//   data_o    slave->master  LINE_W  read line data, valid with ack_o on a read
//   busy_o    slave->master  1       request in flight
// ---------------------------------------------------------------------------
interface line_memory_ctrl_if #(
    parameter int LINE_W = 256
);

    logic [31:0]       addr_i;
    logic              enable_i;
    logic              write_i;
    logic [LINE_W-1:0] data_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;
    logic              busy_o;

    // The cache side drives requests and observes completion.
    modport master (
        output addr_i,
        output enable_i,
        output write_i,
        output data_i,
        input  ack_o,
        input  data_o,
        input  busy_o
    );

    // The memory side observes requests and drives completion.
    modport slave (
        input  addr_i,
        input  enable_i,
        input  write_i,
        input  data_i,
        output ack_o,
        output data_o,
        output busy_o
    );

endinterface : line_memory_ctrl_if

// File: rtl/line_memory_ctrl.sv
// ---------------------------------------------------------------------------
// line_memory_ctrl
//
// Purpose:
//   Off-chip data memory model plus its controller. It serves whole cache
//   lines to the dcache controller with a fixed access latency. Only one
//   request is ever outstanding. A request is latched when accepted in IDLE,
//   and the controller counts down in WAIT. It then completes with a single
//   ack_o cycle (ACK). Reads return the line with the ack. Writes commit to
//   the array on the clock edge that leaves ACK.
//
// Ports:
//   clk_i   in   1   system clock, rising edge
//   rst_i   in   1   asynchronous reset, active low
//   bus     slave modport of line_memory_ctrl_if
//           (addr_i, enable_i, write_i, data_i in; ack_o, data_o, busy_o out)
//
// Parameters:
//   LINE_W   line width in bits
//   DEPTH    number of stored lines, power of two
//   IDX_W    log2(DEPTH)
//   LATENCY  edges from request acceptance to ack, 1..255
// ---------------------------------------------------------------------------
module line_memory_ctrl #(
    parameter int LINE_W  = 256,
    parameter int DEPTH   = 512,
    parameter int IDX_W   = $clog2(DEPTH),
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    line_memory_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ACK  = 2'd2
    } state_t;

    // Controller state and latched request
    state_t            state_q, state_d;
    logic [7:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              write_q, write_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;

    // Registered outputs
    logic              ack_q, ack_d;
    logic [LINE_W-1:0] rdata_q, rdata_d;
    logic              busy_q, busy_d;

    // Line storage. It is deliberately not reset.
    logic [LINE_W-1:0] mem [DEPTH];
    logic              mem_we;

    // Line index of the incoming request. The offset bits inside the line
    // and any address bits above the array are dropped, so the index wraps
    // modulo DEPTH.
    logic [IDX_W-1:0]  req_idx;
    logic              unused_addr_bits;

    assign req_idx          = bus.addr_i[IDX_W+4:5];
    assign unused_addr_bits = ^{bus.addr_i[31:IDX_W+5], bus.addr_i[4:0]};

    // Next-state and output logic. The outputs are computed from the state
    // being entered so that the flops present them in that state's cycle.
    // The read data is captured on the edge that enters ACK. A write that
    // completed earlier is already in the array, so a later read sees it.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        write_d = write_q;
        wdata_d = wdata_q;
        ack_d   = 1'b0;
        rdata_d = '0;
        busy_d  = 1'b0;
        mem_we  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.enable_i) begin
                    idx_d   = req_idx;
                    write_d = bus.write_i;
                    wdata_d = bus.data_i;
                    cnt_d   = 8'(LATENCY - 1);
                    if (LATENCY == 1) begin
                        state_d = ACK;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end

            WAIT: begin
                cnt_d = cnt_q - 8'd1;
                if (cnt_q == 8'd1) begin
                    state_d = ACK;
                end
            end

            ACK: begin
                // The write lands on the edge that leaves ACK. A reset before
                // that edge discards it.
                mem_we  = write_q;
                cnt_d   = 8'd0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_d == ACK) begin
            ack_d = 1'b1;
            if (!write_d) begin
                rdata_d = mem[idx_d];
            end
        end

        busy_d = (state_d != IDLE);
    end

    // State, latched request and output registers
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            write_q <= write_d;
            wdata_q <= wdata_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            busy_q  <= busy_d;
        end
    end

    // Line array write port
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem[idx_q] <= wdata_q;
        end
    end

    assign bus.ack_o  = ack_q;
    assign bus.data_o = rdata_q;
    assign bus.busy_o = busy_q;

endmodule : line_memory_ctrl

// File: tb/tb_line_memory_ctrl.sv
// ---------------------------------------------------------------------------
// tb_line_memory_ctrl
//
// Purpose:
//   Self-checking bench for line_memory_ctrl. The driver issues line
//   requests, directed ones first and then random ones. Each accepted
//   request is pushed onto a scoreboard queue. The expected read data comes
//   from a reference copy of the memory. A separate monitor samples the DUT
//   on every falling edge. For each ack it pops the oldest request and checks
//   the data and the latency. In between acks it checks that data_o is zero
//   and that busy_o matches whether a request is outstanding. The reference
//   memory only takes a write when that write is acknowledged, so a write
//   aborted by reset never reaches it.
// ---------------------------------------------------------------------------
module tb_line_memory_ctrl;

    localparam int LINE_W  = 256;
    localparam int DEPTH   = 512;
    localparam int LATENCY = 10;

    typedef struct {
        logic              wr;
        logic [LINE_W-1:0] data;
        int                idx;
        int                acc;
        int                gap;
    } exp_t;

    logic clk;
    logic rst_i;
    int   cycle;
    int   vectors;
    int   miscompares;
    int   last_ack;
    exp_t sb[$];
    exp_t mon_e;
    logic [LINE_W-1:0] ref_mem [DEPTH];

    line_memory_ctrl_if #(.LINE_W(LINE_W)) bus ();

    line_memory_ctrl #(
        .LINE_W (LINE_W),
        .DEPTH  (DEPTH),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i(clk),
        .rst_i(rst_i),
        .bus  (bus)
    );

    // Clock and edge counter
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [LINE_W-1:0] randLine();
        logic [LINE_W-1:0] v;
        for (int i = 0; i < LINE_W / 32; i++) begin
            v[i*32 +: 32] = $urandom;
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    task automatic failNow(input string name);
        vectors++;
        miscompares++;
        $display("[TB] FAIL %s at cycle %0d", name, cycle);
    endtask

    // Monitor. The consumer samples ack on the rising edge after it is raised.
    // So for a request accepted at edge E, ack must be seen at edge E+LATENCY.
    always @(negedge clk) begin
        if (!rst_i) begin
            checkOutput("reset_ack_busy", LINE_W'({bus.ack_o, bus.busy_o}), '0);
            checkOutput("reset_data", bus.data_o, '0);
        end else if (bus.ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                failNow("unexpected_ack");
            end else begin
                mon_e = sb.pop_front();
                checkOutput("ack_data", bus.data_o, mon_e.wr ? '0 : mon_e.data);
                checkOutput("ack_latency", LINE_W'(cycle - mon_e.acc + 1), LINE_W'(LATENCY));
                checkOutput("ack_busy", LINE_W'(bus.busy_o), LINE_W'(1));
                if (mon_e.gap != 0) begin
                    checkOutput("ack_gap", LINE_W'(cycle - last_ack), LINE_W'(mon_e.gap));
                end
                if (mon_e.wr) begin
                    ref_mem[mon_e.idx] = mon_e.data;
                end
            end
            last_ack = cycle;
        end else begin
            checkOutput("idle_data", bus.data_o, '0);
            checkOutput("busy", LINE_W'(bus.busy_o), LINE_W'(sb.size() != 0));
        end
    end

    // Issues one request. It is called on a falling edge and returns on a
    // falling edge. The request is driven at the first falling edge where the
    // controller is idle, so the next rising edge accepts it. With hold set,
    // enable_i stays high for a back-to-back follow-up request. With withdraw
    // set, enable_i drops and the other request inputs are scrambled once the
    // request is in flight.
    task automatic applyStimulus(input logic [31:0] addr, input logic wr,
                                 input logic [LINE_W-1:0] data, input bit hold,
                                 input bit withdraw, input int gap);
        exp_t e;
        int   n;
        n = 0;
        while (bus.busy_o !== 1'b0) begin
            @(negedge clk);
            n++;
            if (n > 300) begin
                failNow("idle_timeout");
                return;
            end
        end
        bus.enable_i = 1'b1;
        bus.addr_i   = addr;
        bus.write_i  = wr;
        bus.data_i   = data;
        @(posedge clk);
        #1;
        e.wr   = wr;
        e.idx  = int'((addr >> 5) % DEPTH);
        e.data = wr ? data : ref_mem[e.idx];
        e.acc  = cycle;
        e.gap  = gap;
        sb.push_back(e);
        @(negedge clk);
        if (withdraw) begin
            bus.enable_i = 1'b0;
            bus.addr_i   = $urandom;
            bus.write_i  = 1'($urandom);
            bus.data_i   = randLine();
        end else if (!hold) begin
            bus.enable_i = 1'b0;
        end
    endtask

    initial begin
        logic [31:0] addr;
        logic [LINE_W-1:0] d;
        bit hold;
        vectors     = 0;
        miscompares = 0;
        last_ack    = 0;
        rst_i        = 1'b0;
        bus.enable_i = 1'b0;
        bus.addr_i   = '0;
        bus.write_i  = 1'b0;
        bus.data_i   = '0;

        // Preload the array and the reference copy while in reset
        for (int i = 0; i < DEPTH; i++) begin
            d = randLine();
            if (i == 3) d = {32{8'hA5}};
            if (i == 7) d = LINE_W'(8'hFF);
            ref_mem[i] = d;
            dut.mem[i] = d;
        end
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b1;
        @(negedge clk);

        $display("[TB] read of preloaded line 3");
        applyStimulus(32'h60, 1'b0, '0, 1'b0, 1'b0, 0);

        $display("[TB] write line 4 then read it back to back");
        applyStimulus(32'h80, 1'b1, LINE_W'(16'h1234), 1'b1, 1'b0, 0);
        applyStimulus(32'h80, 1'b0, '0, 1'b0, 1'b0, LATENCY + 1);

        $display("[TB] write through wrapped address, read line 1");
        applyStimulus(32'h4000_0020, 1'b1, randLine(), 1'b0, 1'b0, 0);
        applyStimulus(32'h20, 1'b0, '0, 1'b0, 1'b0, 0);

        $display("[TB] enable held across write line 5 and read line 6");
        applyStimulus(32'hA0, 1'b1, randLine(), 1'b1, 1'b0, 0);
        applyStimulus(32'hC0, 1'b0, '0, 1'b0, 1'b0, LATENCY + 1);

        $display("[TB] reset during write to line 7");
        applyStimulus(32'hE0, 1'b1, randLine(), 1'b0, 1'b0, 0);
        repeat (4) @(posedge clk);
        #3 rst_i = 1'b0;
        sb.delete();
        repeat (3) @(posedge clk);
        #3 rst_i = 1'b1;
        @(negedge clk);
        applyStimulus(32'hE0, 1'b0, '0, 1'b0, 1'b0, 0);

        $display("[TB] read withdrawn during wait");
        applyStimulus(32'h1E0, 1'b0, '0, 1'b0, 1'b1, 0);
        applyStimulus(32'h1E0, 1'b0, '0, 1'b0, 1'b0, 0);

        $display("[TB] random traffic");
        for (int k = 0; k < 40; k++) begin
            addr = ($urandom & 32'hFFFF_C000) | (32'($urandom_range(0, 15)) << 5)
                 | ($urandom & 32'h1F);
            hold = (k != 39) && ($urandom_range(0, 2) == 0);
            applyStimulus(addr, 1'($urandom), randLine(), hold,
                          !hold && ($urandom_range(0, 3) == 0), 0);
        end

        // Drain the outstanding request
        for (int n = 0; n < 300 && (sb.size() != 0 || bus.busy_o !== 1'b0); n++) begin
            @(negedge clk);
        end
        if (sb.size() != 0) begin
            failNow("drain_timeout");
        end
        repeat (2) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_line_memory_ctrl
